// File: rtl/turn_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | turn_sequencer : per-turn aim/charge/throw/damage sequencer  (rev 1.0)   |
// +--------------------------------------------------------------------------+
module turn_sequencer #(
  parameter int TURN_TICKS = 600,
  parameter int POWER_MAX  = 100,
  parameter int DAMAGE     = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        next_turn,
  input  logic        dog_turn,
  input  logic        cat_turn,
  input  logic        tick_en,
  input  logic        fire_held,
  input  logic        proj_hit,
  input  logic        proj_miss,
  output logic [6:0]  power,
  output logic        throw_start,
  output logic        dmg_valid,
  output logic [9:0]  dmg_amount,
  output logic        dmg_to_dog,
  output logic        turn_done_dog,
  output logic        turn_done_cat,
  output logic [15:0] time_left,
  output logic [2:0]  seq_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_AIM     = 3'd1,
    S_CHARGE  = 3'd2,
    S_FLIGHT  = 3'd3,
    S_RESOLVE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [15:0] C_TICKS_INIT = 16'(TURN_TICKS);
  localparam logic [6:0]  C_POWER_SAT  = 7'(POWER_MAX);
  localparam logic [10:0] C_DMG_BASE   = 11'(DAMAGE);
  localparam logic [10:0] C_DMG_SAT    = 11'd1023;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        nt_prev_q;
  logic [6:0]  power_q, power_d;
  logic [15:0] time_left_q, time_left_d;
  logic        throw_q, throw_d;
  logic        dmg_valid_q, dmg_valid_d;
  logic [9:0]  dmg_amount_q, dmg_amount_d;
  logic        dmg_to_dog_q, dmg_to_dog_d;
  logic        done_dog_q, done_dog_d;
  logic        done_cat_q, done_cat_d;

  logic [15:0] w_tl_dec;
  logic        w_timeout;
  logic        w_rise;
  logic        w_abort;
  logic [6:0]  w_power_inc;
  logic [10:0] w_dmg_sum;

  always_comb begin
    w_tl_dec    = (tick_en && (time_left_q != 16'd0)) ? (time_left_q - 16'd1) : time_left_q;
    w_timeout   = (w_tl_dec == 16'd0);
    w_rise      = next_turn && !nt_prev_q;
    w_abort     = !next_turn && ((state_q == S_AIM) || (state_q == S_CHARGE) ||
                                 (state_q == S_FLIGHT) || (state_q == S_RESOLVE));
    w_power_inc = (tick_en && fire_held && (power_q < C_POWER_SAT)) ? (power_q + 7'd1) : power_q;
    w_dmg_sum   = C_DMG_BASE + {6'd0, power_q[6:2]};

    state_d      = state_q;
    owner_d      = owner_q;
    power_d      = power_q;
    time_left_d  = time_left_q;
    dmg_amount_d = dmg_amount_q;
    dmg_to_dog_d = dmg_to_dog_q;
    throw_d      = 1'b0;
    dmg_valid_d  = 1'b0;
    done_dog_d   = 1'b0;
    done_cat_d   = 1'b0;

    // An abort freezes power/time_left and suppresses every pulse.
    if (w_abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_rise && (dog_turn ^ cat_turn)) begin
            state_d     = S_AIM;
            owner_d     = dog_turn;
            time_left_d = C_TICKS_INIT;
            power_d     = 7'd0;
          end
        end
        S_AIM: begin
          time_left_d = w_tl_dec;
          if (w_timeout) begin
            state_d    = S_DONE;
            done_dog_d = owner_q;
            done_cat_d = !owner_q;
          end else if (fire_held) begin
            state_d = S_CHARGE;
            power_d = 7'd0;
          end
        end
        S_CHARGE: begin
          time_left_d = w_tl_dec;
          if (!fire_held) begin
            state_d = S_FLIGHT;
            throw_d = 1'b1;
          end else begin
            power_d = w_power_inc;
            if (w_timeout) begin
              state_d = S_FLIGHT;
              throw_d = 1'b1;
            end
          end
        end
        S_FLIGHT: begin
          if (proj_hit) begin
            state_d      = S_RESOLVE;
            dmg_valid_d  = 1'b1;
            dmg_amount_d = (w_dmg_sum > C_DMG_SAT) ? 10'd1023 : w_dmg_sum[9:0];
            dmg_to_dog_d = !owner_q;
          end else if (proj_miss) begin
            state_d    = S_DONE;
            done_dog_d = owner_q;
            done_cat_d = !owner_q;
          end
        end
        S_RESOLVE: begin
          state_d    = S_DONE;
          done_dog_d = owner_q;
          done_cat_d = !owner_q;
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      nt_prev_q    <= 1'b0;
      power_q      <= 7'd0;
      time_left_q  <= 16'd0;
      throw_q      <= 1'b0;
      dmg_valid_q  <= 1'b0;
      dmg_amount_q <= 10'd0;
      dmg_to_dog_q <= 1'b0;
      done_dog_q   <= 1'b0;
      done_cat_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      nt_prev_q    <= next_turn;
      power_q      <= power_d;
      time_left_q  <= time_left_d;
      throw_q      <= throw_d;
      dmg_valid_q  <= dmg_valid_d;
      dmg_amount_q <= dmg_amount_d;
      dmg_to_dog_q <= dmg_to_dog_d;
      done_dog_q   <= done_dog_d;
      done_cat_q   <= done_cat_d;
    end
  end

  assign power         = power_q;
  assign throw_start   = throw_q;
  assign dmg_valid     = dmg_valid_q;
  assign dmg_amount    = dmg_amount_q;
  assign dmg_to_dog    = dmg_to_dog_q;
  assign turn_done_dog = done_dog_q;
  assign turn_done_cat = done_cat_q;
  assign time_left     = time_left_q;
  assign seq_state     = state_q;

endmodule
`default_nettype wire

// File: doc/turn_sequencer.md
TURN_SEQUENCER -- requirements
Module: turn_sequencer

Interface
REQ-001 Parameter TURN_TICKS, default 600, turn time limit in tick_en pulses (1..65535).
REQ-002 Parameter POWER_MAX, default 100, throw power saturation value (1..127).
REQ-003 Parameter DAMAGE, default 10, base damage per hit (1..1023).
REQ-004 clk  in  1  system clock; all state changes on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 next_turn  in  1  level from the game FSM; high while a turn is in progress.
REQ-007 dog_turn, cat_turn  in  1 each  turn owner flags from the game FSM.
REQ-008 tick_en  in  1  one-cycle timebase strobe (e.g. 60 Hz frame tick).
REQ-009 fire_held  in  1  synchronised level of the active player's fire key.
REQ-010 proj_hit, proj_miss  in  1 each  one-cycle projectile outcome pulses.
REQ-011 power  out  7  current throw power; valid with throw_start.
REQ-012 throw_start  out  1  one-cycle launch pulse to projectile block.
REQ-013 dmg_valid  out  1  one-cycle damage pulse; dmg_amount  out  10; dmg_to_dog  out  1 (1 = dog hit, 0 = cat hit).
REQ-014 turn_done_dog, turn_done_cat  out  1 each  one-cycle end-of-turn pulses to the game FSM.
REQ-015 time_left  out  16  remaining turn ticks; seq_state  out  3  state code for display/debug.

Function
REQ-016 States: IDLE=0, AIM=1, CHARGE=2, FLIGHT=3, RESOLVE=4, DONE=5; codes 6-7 return to IDLE next cycle.
REQ-017 Turn start: rising edge of next_turn (registered previous value 0, current 1) in IDLE with exactly one of dog_turn/cat_turn high -> AIM; latch owner (1 = dog); load time_left = TURN_TICKS; power = 0.
REQ-018 Rising edge with both or neither owner flag high -> stay IDLE, no outputs.
REQ-019 time_left decrements by 1 on each tick_en in AIM and CHARGE only; holds elsewhere; never wraps below 0.
REQ-020 AIM: fire_held=1 -> CHARGE next cycle, power=0; time_left reaching 0 -> DONE with no throw (forfeit).
REQ-021 CHARGE: each tick_en with fire_held=1 -> power+1, saturating at POWER_MAX.
REQ-022 CHARGE: fire_held=0 or time_left reaching 0 -> FLIGHT; throw_start=1 for exactly that transition cycle with power holding the final value.
REQ-023 Simultaneous tick_en and release in CHARGE: release wins, power not incremented.
REQ-024 FLIGHT: no timer; proj_hit -> RESOLVE; proj_miss -> DONE; both same cycle -> hit wins.
REQ-025 RESOLVE (1 cycle): dmg_valid=1, dmg_amount = DAMAGE + power/4 (10-bit, saturate 1023), dmg_to_dog = NOT owner; -> DONE.
REQ-026 DONE (1 cycle): turn_done_dog=1 if owner dog else turn_done_cat=1; -> IDLE.
REQ-027 Abort: next_turn=0 in any state other than IDLE/DONE -> IDLE next cycle; no throw_start, dmg_valid or turn_done pulse; power and time_left hold.
REQ-028 Abort takes priority over all other transitions in the same cycle.
REQ-029 proj_hit/proj_miss outside FLIGHT and fire_held outside AIM/CHARGE are ignored.
REQ-030 At most one of throw_start, dmg_valid, turn_done_dog, turn_done_cat is high in any cycle.
REQ-031 All outputs registered; no combinational path input -> output.

Reset
REQ-032 rst_n=0 immediately forces state IDLE, power=0, time_left=0, owner=0, next_turn edge register=0, all pulses and dmg_amount/dmg_to_dog=0, regardless of clk.
REQ-033 Reset mid-turn discards the turn; after release a new next_turn rising edge is required to start.

Verification
REQ-034 Dog turn, fire held 20 ticks then released, proj_hit -> throw_start with power=20, dmg_valid with dmg_amount=15, dmg_to_dog=0, then turn_done_dog one cycle.
REQ-035 Cat turn, no fire, TURN_TICKS=5 -> after 5 tick_en time_left=0, turn_done_cat pulse, no throw_start, no dmg_valid.
REQ-036 Fire held 200 ticks, TURN_TICKS=600 -> power saturates at 100; release -> throw_start power=100; proj_miss -> turn_done only, no dmg_valid.
REQ-037 next_turn dropped during CHARGE -> IDLE next cycle, no pulses; next rising edge starts clean turn with time_left=TURN_TICKS.
REQ-038 rst_n asserted during FLIGHT between clock edges -> outputs zero immediately; proj_hit after release ignored.
REQ-039 proj_hit and proj_miss same cycle in FLIGHT -> dmg_valid next cycle; rising edge with dog_turn=cat_turn=1 -> stays IDLE.
